// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART Tx serializer
// among NUM_REQ byte producers. It runs the TxStart/TxBusy handshake, returns a
// one-cycle Ack to the winner, and aborts when TxBusy never rises after a start.
// Optional packet locking is enabled with the macro UART_SCHED_PACKET_EN.
module uart_tx_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int IDX_W         = 2,
   parameter int START_TIMEOUT = 16
) (
   input  logic                   CLK_100MHz,
   input  logic                   Reset,
   input  logic [NUM_REQ-1:0]     Req,
   input  logic [8*NUM_REQ-1:0]   ReqData,
   input  logic [NUM_REQ-1:0]     ReqLast,
   output logic [NUM_REQ-1:0]     Ack,
   output logic [7:0]             TxData,
   output logic                   TxStart,
   input  logic                   TxBusy,
   output logic [IDX_W-1:0]       GrantIdx,
   output logic                   SchedBusy,
   output logic                   TimeoutErr
);

   localparam int CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_start_q, tx_start_d;
   logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
   logic                 sched_busy_q, sched_busy_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_next;
   logic [NUM_REQ-1:0]   eligible;
   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [7:0]           req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = ReqData[8*g +: 8];
   end

`ifdef UART_SCHED_PACKET_EN
   logic lock_q, lock_d;

   // While a packet is open only the locked requester may be chosen
   always_comb begin
      eligible = lock_q ? (Req & (NUM_REQ'(1) << grant_idx_q)) : Req;
   end
`else
   logic unused_last;
   assign unused_last = ^ReqLast;

   // Without packet locking every requester competes for every byte
   always_comb begin
      eligible = Req;
   end
`endif

   // Search upward from the last grant, wrapping, so the previous winner goes last
   always_comb begin
      int               cand_i;
      logic [IDX_W-1:0] cand;
      win_found = 1'b0;
      win_idx   = grant_idx_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_i = (int'(grant_idx_q) + k) % NUM_REQ;
         cand   = IDX_W'(cand_i);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic of the launch/handshake sequencer
   always_comb begin
      state_d       = state_q;
      ack_d         = '0;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      grant_idx_d   = grant_idx_q;
      timeout_err_d = 1'b0;
      cnt_d         = cnt_q;
      cnt_next      = cnt_q + CNT_W'(1);
`ifdef UART_SCHED_PACKET_EN
      lock_d        = lock_q;
`endif
      case (state_q)
         IDLE: begin
            if (!TxBusy && win_found) begin
               tx_data_d   = req_bytes[win_idx];
               grant_idx_d = win_idx;
               ack_d       = NUM_REQ'(1) << win_idx;
               tx_start_d  = 1'b1;
               state_d     = LAUNCH;
`ifdef UART_SCHED_PACKET_EN
               lock_d      = !ReqLast[win_idx];
`endif
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (TxBusy) begin
               state_d = WAIT_DONE;
            end else begin
               cnt_d = cnt_next;
               if (cnt_next == CNT_W'(START_TIMEOUT - 1)) begin
                  timeout_err_d = 1'b1;
                  state_d       = IDLE;
`ifdef UART_SCHED_PACKET_EN
                  lock_d        = 1'b0;
`endif
               end
            end
         end
         WAIT_DONE: begin
            if (!TxBusy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      sched_busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset aborts whatever is in flight
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         state_q       <= IDLE;
         ack_q         <= '0;
         tx_data_q     <= 8'h00;
         tx_start_q    <= 1'b0;
         grant_idx_q   <= IDX_W'(NUM_REQ - 1);
         sched_busy_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
`ifdef UART_SCHED_PACKET_EN
         lock_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         grant_idx_q   <= grant_idx_d;
         sched_busy_q  <= sched_busy_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
`ifdef UART_SCHED_PACKET_EN
         lock_q        <= lock_d;
`endif
      end
   end

   assign Ack        = ack_q;
   assign TxData     = tx_data_q;
   assign TxStart    = tx_start_q;
   assign GrantIdx   = grant_idx_q;
   assign SchedBusy  = sched_busy_q;
   assign TimeoutErr = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: directed vector table, hand-written corner
// sequences, and randomized byte queues checked against a transaction model.
module tb_uart_tx_scheduler;

   localparam int NUM_REQ       = 4;
   localparam int IDX_W         = 2;
   localparam int START_TIMEOUT = 16;
   localparam logic [31:0] DATA_ALL = {8'h44, 8'h33, 8'h22, 8'h11};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  ack;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  grant_idx;
   logic        sched_busy;
   logic        timeout_err;

   logic        force_busy = 1'b0;
   logic        ser_busy = 1'b0;
   assign tx_busy = force_busy | ser_busy;

   int checks = 0;
   int errors = 0;

   // Serializer model settings and state
   bit ser_enable = 1'b0;
   bit ser_rand = 1'b0;
   int ser_pending = 0;
   int ser_left = 0;
   int ser_len_cur = 10;
   int ser_dly = 1;

   // Transaction model state
   logic [7:0]  qd [NUM_REQ][$];
   bit          ql [NUM_REQ][$];
   logic [3:0]  prev_req;
   logic [31:0] prev_data;
   logic [3:0]  prev_last;
   int          m_last = NUM_REQ - 1;
   bit          m_lock = 1'b0;
   int          m_lock_idx = 0;
   int          grant_log[$];

   typedef struct {
      logic [3:0] req;
      logic [3:0] exp_ack;
      logic [7:0] exp_data;
      logic [1:0] exp_idx;
   } vec_t;
   vec_t vecs [10];

   always #5 clk = ~clk;

   uart_tx_scheduler #(
      .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .START_TIMEOUT(START_TIMEOUT)
   ) dut (
      .CLK_100MHz(clk),
      .Reset(reset),
      .Req(req),
      .ReqData(req_data),
      .ReqLast(req_last),
      .Ack(ack),
      .TxData(tx_data),
      .TxStart(tx_start),
      .TxBusy(tx_busy),
      .GrantIdx(grant_idx),
      .SchedBusy(sched_busy),
      .TimeoutErr(timeout_err)
   );

   // Serializer: on TxStart, raise busy after a delay and hold it for a frame length
   always @(negedge clk) begin
      if (ser_left > 0) begin
         ser_left = ser_left - 1;
         if (ser_left == 0) ser_busy = 1'b0;
      end else if (ser_pending > 0) begin
         ser_pending = ser_pending - 1;
         if (ser_pending == 0) begin
            ser_busy = 1'b1;
            ser_left = ser_len_cur;
         end
      end
      if (ser_enable && tx_start) begin
         ser_dly     = ser_rand ? int'($urandom_range(0, 3)) : 1;
         ser_len_cur = ser_rand ? int'($urandom_range(1, 12)) : 10;
         if (ser_dly == 0) begin
            ser_busy = 1'b1;
            ser_left = ser_len_cur;
         end else begin
            ser_pending = ser_dly;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l);
      req      = r;
      req_data = d;
      req_last = l;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      applyStimulus(4'b0000, 32'h0, 4'b0000);
      repeat (3) @(negedge clk);
      reset      = 1'b0;
      m_last     = NUM_REQ - 1;
      m_lock     = 1'b0;
   endtask

   task automatic wait_start(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (tx_start) ok = 1'b1;
      end
      if (!ok) checkOutput({name, "_start_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (!sched_busy && !tx_busy && !tx_start) ok = 1'b1;
      end
      if (!ok) checkOutput({name, "_idle_timeout"}, 32'd0, 32'd1);
   endtask

   // Round-robin rule: first requesting index after the last grant, wrapping
   function automatic int rr_pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic drive_from_queues();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (qd[i].size() > 0) begin
            req[i]            = 1'b1;
            req_data[8*i +: 8] = qd[i][0];
            req_last[i]       = ql[i][0];
         end else begin
            req[i]            = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
      prev_req  = req;
      prev_data = req_data;
      prev_last = req_last;
   endtask

   // Run the producers' queues to empty, predicting every grant
   task automatic run_queue(input string name, input int budget);
      bit done = 1'b0;
      int w;
      int pending;
      grant_log.delete();
      drive_from_queues();
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (tx_start) begin
            if (m_lock) w = prev_req[m_lock_idx] ? m_lock_idx : -1;
            else        w = rr_pick(prev_req, m_last);
            if (w < 0) begin
               checkOutput({name, "_unexpected_start"}, {31'd0, tx_start}, 32'd0);
            end else begin
               checkOutput({name, "_ack"}, {28'd0, ack}, 32'd1 << w);
               checkOutput({name, "_data"}, {24'd0, tx_data}, {24'd0, prev_data[8*w +: 8]});
               checkOutput({name, "_grant"}, {30'd0, grant_idx}, w);
               m_last = w;
`ifdef UART_SCHED_PACKET_EN
               m_lock     = !prev_last[w];
               m_lock_idx = w;
`endif
               grant_log.push_back(w);
               if (qd[w].size() > 0) begin
                  void'(qd[w].pop_front());
                  void'(ql[w].pop_front());
               end
            end
         end else if (ack != 4'b0000) begin
            checkOutput({name, "_ack_without_start"}, {28'd0, ack}, 32'd0);
         end
         if (timeout_err) m_lock = 1'b0;
         drive_from_queues();
         pending = 0;
         for (int i = 0; i < NUM_REQ; i++) pending += qd[i].size();
         if (pending == 0 && !sched_busy && !tx_busy && !tx_start) done = 1'b1;
      end
      if (!done) checkOutput({name, "_drain_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      bit seen;
      int total;
      int n;
      int exp_pkt[5];

      vecs[0] = '{4'b1111, 4'b0001, 8'h11, 2'd0};
      vecs[1] = '{4'b1111, 4'b0010, 8'h22, 2'd1};
      vecs[2] = '{4'b0001, 4'b0001, 8'h11, 2'd0};
      vecs[3] = '{4'b1000, 4'b1000, 8'h44, 2'd3};
      vecs[4] = '{4'b0110, 4'b0010, 8'h22, 2'd1};
      vecs[5] = '{4'b0110, 4'b0100, 8'h33, 2'd2};
      vecs[6] = '{4'b0101, 4'b0001, 8'h11, 2'd0};
      vecs[7] = '{4'b1010, 4'b0010, 8'h22, 2'd1};
      vecs[8] = '{4'b1010, 4'b1000, 8'h44, 2'd3};
      vecs[9] = '{4'b1111, 4'b0001, 8'h11, 2'd0};

      // Reset values
      do_reset();
      @(negedge clk);
      checkOutput("rst_ack", {28'd0, ack}, 32'd0);
      checkOutput("rst_txdata", {24'd0, tx_data}, 32'd0);
      checkOutput("rst_txstart", {31'd0, tx_start}, 32'd0);
      checkOutput("rst_grant", {30'd0, grant_idx}, 32'd3);
      checkOutput("rst_schedbusy", {31'd0, sched_busy}, 32'd0);
      checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);

      // Vector table: one arbitration per entry
      ser_enable = 1'b1;
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].req, DATA_ALL, 4'b1111);
         wait_start("vec", 20);
         checkOutput("vec_ack", {28'd0, ack}, {28'd0, vecs[v].exp_ack});
         checkOutput("vec_data", {24'd0, tx_data}, {24'd0, vecs[v].exp_data});
         checkOutput("vec_grant", {30'd0, grant_idx}, {30'd0, vecs[v].exp_idx});
         applyStimulus(4'b0000, DATA_ALL, 4'b1111);
         @(negedge clk);
         checkOutput("vec_start_width", {27'd0, tx_start, ack}, 32'd0);
         wait_idle("vec", 40);
      end

      // Fairness with all requesters held high
      do_reset();
      applyStimulus(4'b1111, DATA_ALL, 4'b1111);
      for (int g = 0; g < 5; g++) begin
         wait_start("rot", 40);
         checkOutput("rot_data", {24'd0, tx_data}, 32'h11 * ((g % 4) + 1));
         checkOutput("rot_ack", {28'd0, ack}, 32'd1 << (g % 4));
         @(negedge clk);
         checkOutput("rot_start_width", {31'd0, tx_start}, 32'd0);
      end
      applyStimulus(4'b0000, DATA_ALL, 4'b1111);
      wait_idle("rot", 40);

      // Start timeout: serializer never answers
      do_reset();
      ser_enable = 1'b0;
      applyStimulus(4'b0100, DATA_ALL, 4'b1111);
      wait_start("to", 20);
      seen = 1'b0;
      for (int k = 1; k < START_TIMEOUT; k++) begin
         @(negedge clk);
         if (timeout_err || tx_start) seen = 1'b1;
      end
      checkOutput("to_early_pulse", {31'd0, seen}, 32'd0);
      @(negedge clk);
      checkOutput("to_pulse", {31'd0, timeout_err}, 32'd1);
      checkOutput("to_idle", {31'd0, sched_busy}, 32'd0);
      @(negedge clk);
      checkOutput("to_pulse_width", {31'd0, timeout_err}, 32'd0);
      checkOutput("to_restart", {31'd0, tx_start}, 32'd1);
      checkOutput("to_restart_ack", {28'd0, ack}, 32'b0100);
      applyStimulus(4'b0000, DATA_ALL, 4'b1111);
      wait_idle("to", 40);

      // Foreign frame in progress holds off any grant
      do_reset();
      ser_enable = 1'b1;
      force_busy = 1'b1;
      applyStimulus(4'b0001, DATA_ALL, 4'b1111);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (tx_start || ack != 4'b0000 || sched_busy) seen = 1'b1;
      end
      checkOutput("busy_hold", {31'd0, seen}, 32'd0);
      force_busy = 1'b0;
      @(negedge clk);
      checkOutput("busy_release_start", {31'd0, tx_start}, 32'd1);
      checkOutput("busy_release_ack", {28'd0, ack}, 32'b0001);
      applyStimulus(4'b0000, DATA_ALL, 4'b1111);
      wait_idle("busy", 40);

      // Reset in the middle of a frame
      do_reset();
      applyStimulus(4'b0010, DATA_ALL, 4'b1111);
      wait_start("rstmid", 20);
      applyStimulus(4'b0000, DATA_ALL, 4'b1111);
      repeat (2) @(negedge clk);
      checkOutput("rstmid_busy_before", {31'd0, sched_busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_schedbusy", {31'd0, sched_busy}, 32'd0);
      checkOutput("rstmid_ack_start", {27'd0, tx_start, ack}, 32'd0);
      checkOutput("rstmid_grant", {30'd0, grant_idx}, 32'd3);
      checkOutput("rstmid_txdata", {24'd0, tx_data}, 32'd0);
      reset  = 1'b0;
      m_last = NUM_REQ - 1;
      m_lock = 1'b0;
      wait_idle("rstmid", 40);

      // Packet sequence: requester 0 sends three bytes, requester 1 two
      do_reset();
      qd[0].push_back(8'hA0); ql[0].push_back(1'b0);
      qd[0].push_back(8'hA1); ql[0].push_back(1'b0);
      qd[0].push_back(8'hA2); ql[0].push_back(1'b1);
      qd[1].push_back(8'hB0); ql[1].push_back(1'b1);
      qd[1].push_back(8'hB1); ql[1].push_back(1'b1);
      run_queue("pkt", 400);
`ifdef UART_SCHED_PACKET_EN
      exp_pkt = '{0, 0, 0, 1, 1};
`else
      exp_pkt = '{0, 1, 0, 1, 0};
`endif
      checkOutput("pkt_count", grant_log.size(), 32'd5);
      n = (grant_log.size() < 5) ? grant_log.size() : 5;
      for (int i = 0; i < n; i++) checkOutput("pkt_order", grant_log[i], exp_pkt[i]);

      // Randomized producer queues with a randomized serializer
      ser_rand = 1'b1;
      for (int round = 0; round < 4; round++) begin
         do_reset();
         total = 0;
         for (int i = 0; i < NUM_REQ; i++) begin
            n = int'($urandom_range(0, 6));
            for (int b = 0; b < n; b++) begin
               qd[i].push_back(8'($urandom));
               ql[i].push_back((b == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
            end
            total += n;
         end
         run_queue("rand", 3000);
         checkOutput("rand_count", grant_log.size(), total);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
